// File: rtl/axil_prewrap_bridge.sv
// AXI4-Lite slave that turns each write into a one-cycle address/message pulse
// and each read into a fixed-latency address/sample on a prewrapper port pair.
module axil_prewrap_bridge #(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] axi_wr_addr,
  output logic [31:0] axi_wr_msg,
  output logic [31:0] axi_rd_addr,
  input  logic [31:0] axi_rd_msg
);

  // Handshakes: a beat transfers on a rising clk edge where valid && ready.
  // Readies depend only on state, holding registers, reset and (for AR) the
  // write valids; no valid is ever waited on by this block before asserting.
  typedef enum logic [2:0] {
    IDLE,
    WR_PULSE,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e      state_q, state_d;
  logic        aw_full_q, aw_full_d;
  logic        w_full_q, w_full_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic        prio_wr_q, prio_wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_err_q, rd_err_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_msg_q, wr_msg_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;

  logic        idle;
  logic        aw_rdy, w_rdy, ar_rdy;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_go;
  logic [31:0] wr_addr_eff, wr_data_eff;

  assign idle   = (state_q == IDLE);
  assign aw_rdy = idle && !aw_full_q && !reset;
  assign w_rdy  = idle && !w_full_q && !reset;
  // A read may only start with both holders empty; if a full write arrives
  // in the same cycle, the round-robin pointer decides who goes first.
  assign ar_rdy = idle && !aw_full_q && !w_full_q && !reset &&
                  !(s_awvalid && s_wvalid && prio_wr_q);

  assign aw_hs = s_awvalid && aw_rdy;
  assign w_hs  = s_wvalid && w_rdy;
  assign ar_hs = s_arvalid && ar_rdy;

  assign wr_addr_eff = aw_full_q ? aw_addr_q : s_awaddr;
  assign wr_data_eff = w_full_q ? w_data_q : s_wdata;
  assign wr_go       = idle && (aw_full_q || aw_hs) && (w_full_q || w_hs) && !ar_hs;

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    prio_wr_d = prio_wr_q;
    cnt_d     = cnt_q;
    rd_err_d  = rd_err_q;
    wr_addr_d = wr_addr_q;
    wr_msg_d  = wr_msg_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
    end

    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          prio_wr_d = 1'b1;
          cnt_d     = 4'(RD_LAT);
          rd_err_d  = (s_araddr == IDLE_ADDR);
          // A parking-address read leaves the bus parked by construction.
          rd_addr_d = s_araddr;
          state_d   = RD_WAIT;
        end else if (wr_go) begin
          prio_wr_d = 1'b0;
          if (wr_addr_eff != IDLE_ADDR) begin
            wr_addr_d = wr_addr_eff;
            wr_msg_d  = wr_data_eff;
          end
          state_d = WR_PULSE;
        end
      end
      WR_PULSE: begin
        wr_addr_d = IDLE_ADDR;
        bvalid_d  = 1'b1;
        bresp_d   = (aw_addr_q == IDLE_ADDR) ? RESP_SLVERR : RESP_OKAY;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd1) begin
          rdata_d   = rd_err_q ? 32'h0 : axi_rd_msg;
          rresp_d   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          rd_addr_d = IDLE_ADDR;
          state_d   = RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      prio_wr_q <= 1'b1;
      cnt_q     <= 4'd0;
      rd_err_q  <= 1'b0;
      wr_addr_q <= IDLE_ADDR;
      wr_msg_q  <= 32'h0;
      rd_addr_q <= IDLE_ADDR;
      rdata_q   <= 32'h0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      prio_wr_q <= prio_wr_d;
      cnt_q     <= cnt_d;
      rd_err_q  <= rd_err_d;
      wr_addr_q <= wr_addr_d;
      wr_msg_q  <= wr_msg_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign s_awready   = aw_rdy;
  assign s_wready    = w_rdy;
  assign s_arready   = ar_rdy;
  assign s_bvalid    = bvalid_q;
  assign s_bresp     = bresp_q;
  assign s_rvalid    = rvalid_q;
  assign s_rdata     = rdata_q;
  assign s_rresp     = rresp_q;
  assign axi_wr_addr = wr_addr_q;
  assign axi_wr_msg  = wr_msg_q;
  assign axi_rd_addr = rd_addr_q;

endmodule

// File: doc/axil_prewrap_bridge.md
AXIL_PREWRAP_BRIDGE -- requirements
Module: axil_prewrap_bridge

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from driving axi_rd_addr to sampling axi_rd_msg (legal range 1..15).
REQ-002 SHALL have parameter IDLE_ADDR, default 32'h0000_0000: parking address driven on axi_rd_addr/axi_wr_addr when idle; the downstream treats it as no-op.
REQ-003 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous active-high reset); single clock domain.
REQ-004 SHALL have AXI4-Lite slave write ports: s_awaddr in 32, s_awvalid in 1, s_awready out 1, s_wdata in 32, s_wvalid in 1, s_wready out 1, s_bresp out 2, s_bvalid out 1, s_bready in 1.
REQ-005 SHALL have AXI4-Lite slave read ports: s_araddr in 32, s_arvalid in 1, s_arready out 1, s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1.
REQ-006 SHALL have prewrapper-side ports: axi_wr_addr out 32, axi_wr_msg out 32, axi_rd_addr out 32, axi_rd_msg in 32.

Function
REQ-007 SHALL implement FSM states IDLE, WR_PULSE, WR_RESP, RD_WAIT, RD_RESP.
REQ-008 In IDLE, s_awready and s_wready SHALL be high while the respective holding register is empty; AW and W SHALL be captured independently, in the same or in different cycles.
REQ-009 In IDLE, s_arready SHALL be high only when no AW or W beat is held.
REQ-010 When AW and W are both held (and no read is being granted), FSM SHALL go to WR_PULSE next cycle.
REQ-011 When a complete write (AW+W held) and s_arvalid are both eligible in the same IDLE cycle, grant SHALL alternate, starting with write after reset; the loser waits.
REQ-012 WR_PULSE SHALL last exactly 1 cycle: axi_wr_addr = captured awaddr, axi_wr_msg = captured wdata; then WR_RESP.
REQ-013 Outside WR_PULSE, axi_wr_addr SHALL equal IDLE_ADDR; axi_wr_msg SHALL hold its last value.
REQ-014 A write with awaddr == IDLE_ADDR SHALL skip the pulse (axi_wr_addr stays IDLE_ADDR) and respond SLVERR (2'b10); otherwise bresp = OKAY (2'b00).
REQ-015 WR_RESP SHALL assert s_bvalid with bresp stable until s_bready; on the handshake cycle it SHALL clear the holding registers and return to IDLE.
REQ-016 On an AR handshake, FSM SHALL drive axi_rd_addr = araddr from the next cycle and enter RD_WAIT with a down-counter loaded to RD_LAT.
REQ-017 In RD_WAIT, axi_rd_msg SHALL be registered into s_rdata when the counter reaches 1, then RD_RESP; total AR-handshake-to-s_rvalid latency = RD_LAT+1 cycles.
REQ-018 axi_rd_addr SHALL equal IDLE_ADDR outside RD_WAIT.
REQ-019 A read with araddr == IDLE_ADDR SHALL return s_rdata = 0, rresp = SLVERR, without driving axi_rd_addr, and with the same latency.
REQ-020 RD_RESP SHALL hold s_rvalid, s_rdata and s_rresp stable until s_rready, then return to IDLE.
REQ-021 Only one transaction SHALL be outstanding; s_awready, s_wready and s_arready SHALL be low in every non-IDLE state.
REQ-022 Address bits [1:0] SHALL be forwarded unmodified; there is no alignment check.

Reset
REQ-023 While reset is high at a clk edge: FSM to IDLE; holding registers empty; grant pointer to write; s_bvalid = s_rvalid = 0; s_bresp = s_rresp = 2'b00; s_rdata = 0; axi_wr_addr = axi_rd_addr = IDLE_ADDR; axi_wr_msg = 0; s_awready = s_wready = s_arready = 0 during reset, rising in the first cycle after reset deasserts.
REQ-024 Reset asserted mid-transaction SHALL abandon it without issuing a wr pulse or a response.

Verification
REQ-025 AW(0x10) and W(0xDEADBEEF) in the same cycle, bready=1 -> one cycle with axi_wr_addr=0x10 and axi_wr_msg=0xDEADBEEF, then bvalid with bresp=00.
REQ-026 AW(0x14) at cycle 0, W(0x5) at cycle 3 -> no pulse before cycle 4, one pulse after W captured, bresp=00.
REQ-027 RD_LAT=3, AR(0x20), axi_rd_msg=0xA5A5_0001 -> rvalid exactly 4 cycles after AR handshake, rdata=0xA5A5_0001, rresp=00; with rready low 5 cycles -> rdata held.
REQ-028 Write and read eligible in the same cycle, twice in a row -> order W, R, W, R.
REQ-029 Write to 0x0 -> no wr pulse, bresp=10; read 0x0 -> rdata=0, rresp=10.
REQ-030 Reset in RD_WAIT -> no rvalid, axi_rd_addr=IDLE_ADDR the next cycle, s_arready high in the first cycle after reset deasserts.
